// File: rtl/lp_expect_ctrl_pkg.sv
// Shared types and constants for the forward-edge landing-pad CFI sequencer.
package lp_expect_ctrl_pkg;

  localparam int XLEN       = 64;
  localparam int VLEN       = 64;
  localparam int LP_LABEL_W = 20;

  typedef enum logic {
    NO_LP_EXPECTED = 1'b0,
    LP_EXPECTED    = 1'b1
  } elp_t;

  typedef enum logic [1:0] {
    LP_IDLE   = 2'd0,
    LP_EXPECT = 2'd1,
    LP_FAULT  = 2'd2
  } lp_state_e;

  localparam logic [1:0] CFI_MISMATCH = 2'b00;
  localparam logic [1:0] CFI_IDLE     = 2'b01;
  localparam logic [1:0] CFI_NA       = 2'b10;
  localparam logic [1:0] CFI_DONE     = 2'b11;

  localparam logic [XLEN-1:0] SW_CHECK        = 64'd18;
  localparam logic [XLEN-1:0] LPAD_FAULT_TVAL = 64'd2;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;

  // x1/x5 are link registers and x7 is the software-guarded label register.
  function automatic logic is_exempt_rs1(input logic [4:0] rs1);
    return (rs1 == 5'd1) || (rs1 == 5'd5) || (rs1 == 5'd7);
  endfunction

endpackage

// File: rtl/lp_expect_ctrl_if.sv
// Commit-side and trap-side signal bundle between the commit stage and the CFI sequencer.
interface lp_expect_ctrl_if #(
  parameter int LABEL_W = 20,
  parameter int CNT_W   = 16
);
  import lp_expect_ctrl_pkg::*;

  logic               xlpad_i;
  logic               debug_mode_i;
  logic               jalr_commit_i;
  logic [4:0]         jalr_rs1_i;
  logic [LABEL_W-1:0] jalr_label_i;
  logic               commit_valid_i;
  logic               commit_is_lpad_i;
  logic [LABEL_W-1:0] commit_label_i;
  logic [VLEN-1:0]    commit_pc_i;
  logic               trap_taken_i;
  logic               trap_ret_i;
  logic               trap_pelp_i;
  elp_t               elp_o;
  logic               pelp_o;
  logic [LABEL_W-1:0] exp_label_o;
  exception_t         cfi_fault_o;
  logic [1:0]         complete_cfi_o;
  logic [CNT_W-1:0]   viol_cnt_o;

  modport slave (
    input  xlpad_i, debug_mode_i, jalr_commit_i, jalr_rs1_i, jalr_label_i,
           commit_valid_i, commit_is_lpad_i, commit_label_i, commit_pc_i,
           trap_taken_i, trap_ret_i, trap_pelp_i,
    output elp_o, pelp_o, exp_label_o, cfi_fault_o, complete_cfi_o, viol_cnt_o
  );

  modport master (
    output xlpad_i, debug_mode_i, jalr_commit_i, jalr_rs1_i, jalr_label_i,
           commit_valid_i, commit_is_lpad_i, commit_label_i, commit_pc_i,
           trap_taken_i, trap_ret_i, trap_pelp_i,
    input  elp_o, pelp_o, exp_label_o, cfi_fault_o, complete_cfi_o, viol_cnt_o
  );

endinterface

// File: rtl/lp_expect_ctrl_label_match.sv
// Landing-pad label compare: a zero LPAD label is a wildcard that accepts any expected label.
module lp_label_match #(
  parameter int LABEL_W = 20
) (
  input  logic               is_lpad_i,
  input  logic [LABEL_W-1:0] label_i,
  input  logic [LABEL_W-1:0] exp_label_i,
  output logic               match_o
);

  assign match_o = is_lpad_i & ((label_i == '0) | (label_i == exp_label_i));

endmodule

// File: rtl/lp_expect_ctrl.sv
// Expected-landing-pad sequencer: arms on indirect jumps, checks the next commit is a
// matching LPAD, raises the software-check fault and carries ELP across traps.
module lp_expect_ctrl
  import lp_expect_ctrl_pkg::*;
#(
  parameter int LABEL_W = LP_LABEL_W,
  parameter int CNT_W   = 16
) (
  input logic             clk_i,
  input logic             rst_i,
  lp_expect_ctrl_if.slave bus
);

  lp_state_e          state_q;
  logic [LABEL_W-1:0] exp_label_q;
  logic               pelp_q;
  logic [1:0]         complete_q;
  logic [CNT_W-1:0]   viol_cnt_q;
  logic               lpad_ok;
  logic               cfi_en;
  logic               unused_pc;

  lp_label_match #(.LABEL_W(LABEL_W)) u_label_match (
    .is_lpad_i   (bus.commit_is_lpad_i),
    .label_i     (bus.commit_label_i),
    .exp_label_i (exp_label_q),
    .match_o     (lpad_ok)
  );

  assign cfi_en = bus.xlpad_i & ~bus.debug_mode_i;

  // The commit PC is only of interest to the trap path (epc), not to the ELP check.
  assign unused_pc = ^bus.commit_pc_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= LP_IDLE;
      exp_label_q <= '0;
      pelp_q      <= 1'b0;
      complete_q  <= CFI_IDLE;
      viol_cnt_q  <= '0;
    end else begin
      complete_q <= CFI_IDLE;
      if (bus.trap_taken_i) begin
        pelp_q  <= (state_q != LP_IDLE);
        state_q <= LP_IDLE;
      end else if (bus.trap_ret_i) begin
        state_q <= (bus.trap_pelp_i & bus.xlpad_i) ? LP_EXPECT : LP_IDLE;
      end else if (!cfi_en) begin
        state_q    <= LP_IDLE;
        complete_q <= CFI_NA;
      end else begin
        unique case (state_q)
          LP_IDLE: begin
            if (bus.jalr_commit_i && !is_exempt_rs1(bus.jalr_rs1_i)) begin
              state_q     <= LP_EXPECT;
              exp_label_q <= bus.jalr_label_i;
            end
          end
          LP_EXPECT: begin
            if (bus.commit_valid_i && lpad_ok) begin
              state_q    <= LP_IDLE;
              complete_q <= CFI_DONE;
            end else if (bus.commit_valid_i || bus.jalr_commit_i) begin
              // Any non-matching commit, including another JALR, violates the expectation.
              state_q    <= LP_FAULT;
              complete_q <= CFI_MISMATCH;
              if (viol_cnt_q != '1) begin
                viol_cnt_q <= viol_cnt_q + CNT_W'(1);
              end
            end
          end
          LP_FAULT: begin
          end
          default: state_q <= LP_IDLE;
        endcase
      end
    end
  end

  // A fault keeps ELP at LP_EXPECTED so trap entry saves it into xPELP.
  assign bus.elp_o          = (state_q == LP_IDLE) ? NO_LP_EXPECTED : LP_EXPECTED;
  assign bus.pelp_o         = pelp_q;
  assign bus.exp_label_o    = exp_label_q;
  assign bus.complete_cfi_o = complete_q;
  assign bus.viol_cnt_o     = viol_cnt_q;

  always_comb begin
    bus.cfi_fault_o = '0;
    if (state_q == LP_FAULT) begin
      bus.cfi_fault_o.valid = 1'b1;
      bus.cfi_fault_o.cause = SW_CHECK;
      bus.cfi_fault_o.tval  = LPAD_FAULT_TVAL;
    end
  end

  a_single_commit: assert property (@(posedge clk_i) disable iff (rst_i)
    !(bus.jalr_commit_i && bus.commit_valid_i));

endmodule

// File: tb/tb_lp_expect_ctrl.sv
// Self-checking bench: directed scenarios plus randomized commit/trap traffic against a behavioural model.
module tb_lp_expect_ctrl;

  localparam int LW   = 20;
  localparam int CW   = 6;
  localparam int MAXV = (1 << CW) - 1;

  logic clk;
  logic rst;

  lp_expect_ctrl_if #(.LABEL_W(LW), .CNT_W(CW)) bus ();

  lp_expect_ctrl #(.LABEL_W(LW), .CNT_W(CW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int test_cnt = 0;
  int fail_cnt = 0;

  // Model: mode 0 = nothing owed, 1 = landing pad owed, 2 = fault outstanding.
  int          m_mode;
  logic [LW-1:0] m_label;
  bit          m_pelp;
  int          m_cpl;
  int          m_viol;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    test_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_label = '0;
    m_pelp  = 1'b0;
    m_cpl   = 1;
    m_viol  = 0;
  endtask

  task automatic model_step(input bit jalr, input logic [4:0] rs1, input logic [LW-1:0] jl,
                            input bit cv, input bit lpad, input logic [LW-1:0] cl,
                            input bit tt, input bit tr, input bit tp, input bit xl, input bit dbg);
    m_cpl = 1;
    if (tt) begin
      m_pelp = (m_mode != 0);
      m_mode = 0;
    end else if (tr) begin
      m_mode = (tp && xl) ? 1 : 0;
    end else if (!xl || dbg) begin
      m_mode = 0;
      m_cpl  = 2;
    end else if (m_mode == 0) begin
      if (jalr && !(rs1 == 5'd1 || rs1 == 5'd5 || rs1 == 5'd7)) begin
        m_mode  = 1;
        m_label = jl;
      end
    end else if (m_mode == 1) begin
      if (cv && lpad && (cl == 0 || cl == m_label)) begin
        m_mode = 0;
        m_cpl  = 3;
      end else if (cv || jalr) begin
        m_mode = 2;
        m_cpl  = 0;
        if (m_viol < MAXV) m_viol++;
      end
    end
  endtask

  task automatic compare_all();
    check_val("elp", bus.elp_o, (m_mode != 0));
    check_val("fault_valid", bus.cfi_fault_o.valid, (m_mode == 2));
    if (m_mode == 2) begin
      check_val("fault_tval", bus.cfi_fault_o.tval, 64'd2);
      check_val("fault_cause", bus.cfi_fault_o.cause, 64'd18);
    end
    check_val("pelp", bus.pelp_o, m_pelp);
    check_val("exp_label", bus.exp_label_o, m_label);
    check_val("complete", bus.complete_cfi_o, m_cpl);
    check_val("viol_cnt", bus.viol_cnt_o, m_viol);
  endtask

  task automatic drive(input bit jalr, input logic [4:0] rs1, input logic [LW-1:0] jl,
                       input bit cv, input bit lpad, input logic [LW-1:0] cl,
                       input bit tt, input bit tr, input bit tp, input bit xl, input bit dbg);
    bus.jalr_commit_i    = jalr;
    bus.jalr_rs1_i       = rs1;
    bus.jalr_label_i     = jl;
    bus.commit_valid_i   = cv;
    bus.commit_is_lpad_i = lpad;
    bus.commit_label_i   = cl;
    bus.commit_pc_i      = {$urandom, $urandom};
    bus.trap_taken_i     = tt;
    bus.trap_ret_i       = tr;
    bus.trap_pelp_i      = tp;
    bus.xlpad_i          = xl;
    bus.debug_mode_i     = dbg;
    model_step(jalr, rs1, jl, cv, lpad, cl, tt, tr, tp, xl, dbg);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_jalr(input logic [4:0] rs1, input logic [LW-1:0] jl);
    drive(1, rs1, jl, 0, 0, '0, 0, 0, 0, 1, 0);
  endtask

  task automatic do_commit(input bit lpad, input logic [LW-1:0] cl);
    drive(0, 5'd0, '0, 1, lpad, cl, 0, 0, 0, 1, 0);
  endtask

  task automatic do_trap();
    drive(0, 5'd0, '0, 0, 0, '0, 1, 0, 0, 1, 0);
  endtask

  task automatic do_idle();
    drive(0, 5'd0, '0, 0, 0, '0, 0, 0, 0, 1, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_elp"}, bus.elp_o, 0);
    check_val({tag, "_pelp"}, bus.pelp_o, 0);
    check_val({tag, "_label"}, bus.exp_label_o, 0);
    check_val({tag, "_fault"}, bus.cfi_fault_o.valid, 0);
    check_val({tag, "_cpl"}, bus.complete_cfi_o, 2'b01);
    check_val({tag, "_viol"}, bus.viol_cnt_o, 0);
  endtask

  initial begin
    logic [4:0] links [3] = '{5'd1, 5'd5, 5'd7};
    bit jalr, cv, lpad, tt, tr, tp, xl, dbg;
    logic [4:0] rs1;
    logic [LW-1:0] jl, cl;
    int r;

    rst = 1'b1;
    bus.jalr_commit_i = 0; bus.jalr_rs1_i = '0; bus.jalr_label_i = '0;
    bus.commit_valid_i = 0; bus.commit_is_lpad_i = 0; bus.commit_label_i = '0;
    bus.commit_pc_i = '0; bus.trap_taken_i = 0; bus.trap_ret_i = 0; bus.trap_pelp_i = 0;
    bus.xlpad_i = 1; bus.debug_mode_i = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_vals("reset");

    // Matching landing pad
    do_jalr(5'd10, 20'h00ABC);
    check_val("match_elp_armed", bus.elp_o, 1);
    do_commit(1, 20'h00ABC);
    check_val("match_cpl", bus.complete_cfi_o, 2'b11);
    check_val("match_nofault", bus.cfi_fault_o.valid, 0);
    check_val("match_elp_clear", bus.elp_o, 0);

    // Label mismatch faults and holds until trap
    do_jalr(5'd10, 20'h00ABC);
    do_commit(1, 20'h00123);
    check_val("mis_fault", bus.cfi_fault_o.valid, 1);
    check_val("mis_tval", bus.cfi_fault_o.tval, 64'd2);
    check_val("mis_cpl", bus.complete_cfi_o, 2'b00);
    check_val("mis_viol", bus.viol_cnt_o, 1);
    do_idle();
    check_val("mis_hold", bus.cfi_fault_o.valid, 1);
    do_trap();
    check_val("mis_trap_clear", bus.cfi_fault_o.valid, 0);
    check_val("mis_trap_pelp", bus.pelp_o, 1);

    // Non-LPAD commit faults; wildcard label accepted
    do_jalr(5'd10, 20'h00ABC);
    do_commit(0, 20'h0);
    check_val("add_fault", bus.cfi_fault_o.valid, 1);
    check_val("add_viol", bus.viol_cnt_o, 2);
    do_trap();
    do_jalr(5'd12, 20'h00555);
    do_commit(1, 20'h0);
    check_val("wild_cpl", bus.complete_cfi_o, 2'b11);

    // Exempt rs1 never arms; trap from idle clears pelp
    do_trap();
    check_val("idle_trap_pelp", bus.pelp_o, 0);
    do_jalr(5'd1, 20'h00ABC);
    check_val("x1_elp", bus.elp_o, 0);
    do_commit(0, 20'h0);
    check_val("x1_cpl", bus.complete_cfi_o, 2'b01);
    do_jalr(5'd7, 20'h00ABC);
    do_commit(0, 20'h0);
    check_val("x7_nofault", bus.cfi_fault_o.valid, 0);

    // Trap out of EXPECT and xRET back into it
    do_jalr(5'd10, 20'h00777);
    do_trap();
    check_val("trap_pelp", bus.pelp_o, 1);
    check_val("trap_elp", bus.elp_o, 0);
    do_idle();
    drive(0, 5'd0, '0, 0, 0, '0, 0, 1, 1, 1, 0);
    check_val("ret_elp", bus.elp_o, 1);
    check_val("ret_label", bus.exp_label_o, 20'h00777);
    do_commit(1, 20'h00777);
    check_val("ret_cpl", bus.complete_cfi_o, 2'b11);

    // Enforcement disabled or debug mode
    drive(1, 5'd10, 20'h00ABC, 0, 0, '0, 0, 0, 0, 0, 0);
    drive(0, 5'd0, '0, 1, 0, '0, 0, 0, 0, 0, 0);
    check_val("nolp_cpl", bus.complete_cfi_o, 2'b10);
    check_val("nolp_nofault", bus.cfi_fault_o.valid, 0);
    drive(1, 5'd10, 20'h00ABC, 0, 0, '0, 0, 0, 0, 1, 1);
    drive(0, 5'd0, '0, 1, 0, '0, 0, 0, 0, 1, 1);
    check_val("dbg_cpl", bus.complete_cfi_o, 2'b10);
    check_val("dbg_nofault", bus.cfi_fault_o.valid, 0);

    // Saturating violation counter
    for (int i = 0; i < MAXV + 5; i++) begin
      do_jalr(5'd11, 20'h00042);
      do_commit(0, 20'h0);
      do_trap();
    end
    check_val("sat_viol", bus.viol_cnt_o, MAXV);

    // Asynchronous reset while a fault is outstanding
    do_jalr(5'd11, 20'h00042);
    do_commit(0, 20'h0);
    #3;
    rst = 1'b1;
    #1;
    check_reset_vals("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      r    = $urandom_range(0, 9);
      jalr = (r < 3);
      cv   = (r >= 3 && r < 7);
      rs1  = ($urandom_range(0, 3) == 0) ? links[$urandom_range(0, 2)] : 5'($urandom_range(0, 31));
      jl   = ($urandom_range(0, 1) == 0) ? 20'h00ABC : LW'($urandom);
      lpad = ($urandom_range(0, 9) < 6);
      case ($urandom_range(0, 3))
        0:       cl = '0;
        1:       cl = m_label;
        2:       cl = 20'h00ABC;
        default: cl = LW'($urandom);
      endcase
      tt  = ($urandom_range(0, 19) == 0);
      tr  = ($urandom_range(0, 19) == 0);
      tp  = $urandom_range(0, 1) == 1;
      xl  = ($urandom_range(0, 19) != 0);
      dbg = ($urandom_range(0, 24) == 0);
      drive(jalr, rs1, jl, cv, lpad, cl, tt, tr, tp, xl, dbg);
    end

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
